// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with load-use hazard detection and
// branch/jump flush control; counts every bubble it injects into E.
module id_ex_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  HoldIn,
    input  logic                  ValidD,
    input  logic                  BranchD,
    input  logic                  JumpD,
    input  logic [1:0]            ResultSrcD,
    input  logic                  MemWriteD,
    input  logic                  ALUSrcAD,
    input  logic                  ALUSrcBD,
    input  logic                  RegWriteD,
    input  logic                  LdSrcD,
    input  logic                  StSrcD,
    input  logic [3:0]            ALUControlD,
    input  logic [XLEN-1:0]       RD1D,
    input  logic [XLEN-1:0]       RD2D,
    input  logic [XLEN-1:0]       PCD,
    input  logic [XLEN-1:0]       ImmExtD,
    input  logic [XLEN-1:0]       PCPlus4D,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] RdD,
    input  logic                  PCSrcE,
    output logic                  BranchE,
    output logic                  JumpE,
    output logic [1:0]            ResultSrcE,
    output logic                  MemWriteE,
    output logic                  ALUSrcAE,
    output logic                  ALUSrcBE,
    output logic                  RegWriteE,
    output logic                  LdSrcE,
    output logic                  StSrcE,
    output logic [3:0]            ALUControlE,
    output logic [XLEN-1:0]       RD1E,
    output logic [XLEN-1:0]       RD2E,
    output logic [XLEN-1:0]       PCE,
    output logic [XLEN-1:0]       ImmExtE,
    output logic [XLEN-1:0]       PCPlus4E,
    output logic [REG_ADDR_W-1:0] Rs1E,
    output logic [REG_ADDR_W-1:0] Rs2E,
    output logic [REG_ADDR_W-1:0] RdE,
    output logic                  ValidE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  FlushD,
    output logic [CNT_W-1:0]      BubbleCount
);

    logic load_use;
    logic bubble;
    logic cnt_sat;

    // Both rs fields are compared regardless of opcode; a spurious stall is harmless.
    assign load_use = ValidE & RegWriteE & (ResultSrcE == 2'b01) &
                      (RdE != '0) & ValidD &
                      ((Rs1D == RdE) | (Rs2D == RdE));

    assign bubble  = PCSrcE | load_use;
    assign cnt_sat = (BubbleCount == {CNT_W{1'b1}});

    assign StallF = HoldIn | (load_use & ~PCSrcE);
    assign StallD = StallF;
    assign FlushD = PCSrcE & ~HoldIn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            BranchE     <= 1'b0;
            JumpE       <= 1'b0;
            ResultSrcE  <= 2'b00;
            MemWriteE   <= 1'b0;
            ALUSrcAE    <= 1'b0;
            ALUSrcBE    <= 1'b0;
            RegWriteE   <= 1'b0;
            LdSrcE      <= 1'b0;
            StSrcE      <= 1'b0;
            ALUControlE <= 4'd0;
            RD1E        <= '0;
            RD2E        <= '0;
            PCE         <= '0;
            ImmExtE     <= '0;
            PCPlus4E    <= '0;
            Rs1E        <= '0;
            Rs2E        <= '0;
            RdE         <= '0;
            ValidE      <= 1'b0;
            BubbleCount <= '0;
        end else if (HoldIn) begin
            BubbleCount <= BubbleCount;
        end else if (bubble) begin
            // Flush wins over load-use; either way exactly one bubble is counted.
            BranchE     <= 1'b0;
            JumpE       <= 1'b0;
            ResultSrcE  <= 2'b00;
            MemWriteE   <= 1'b0;
            ALUSrcAE    <= 1'b0;
            ALUSrcBE    <= 1'b0;
            RegWriteE   <= 1'b0;
            LdSrcE      <= 1'b0;
            StSrcE      <= 1'b0;
            ALUControlE <= 4'd0;
            RD1E        <= '0;
            RD2E        <= '0;
            PCE         <= '0;
            ImmExtE     <= '0;
            PCPlus4E    <= '0;
            Rs1E        <= '0;
            Rs2E        <= '0;
            RdE         <= '0;
            ValidE      <= 1'b0;
            if (!cnt_sat)
                BubbleCount <= BubbleCount + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            BranchE     <= BranchD;
            JumpE       <= JumpD;
            ResultSrcE  <= ResultSrcD;
            MemWriteE   <= MemWriteD;
            ALUSrcAE    <= ALUSrcAD;
            ALUSrcBE    <= ALUSrcBD;
            RegWriteE   <= RegWriteD;
            LdSrcE      <= LdSrcD;
            StSrcE      <= StSrcD;
            ALUControlE <= ALUControlD;
            RD1E        <= RD1D;
            RD2E        <= RD2D;
            PCE         <= PCD;
            ImmExtE     <= ImmExtD;
            PCPlus4E    <= PCPlus4D;
            Rs1E        <= Rs1D;
            Rs2E        <= Rs2D;
            RdE         <= RdD;
            ValidE      <= ValidD;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against both DUT instances.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        HoldIn, ValidD, BranchD, JumpD, MemWriteD, ALUSrcAD, ALUSrcBD;
    logic        RegWriteD, LdSrcD, StSrcD, PCSrcE;
    logic [1:0]  ResultSrcD;
    logic [3:0]  ALUControlD;
    logic [31:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D;
    logic [4:0]  Rs1D, Rs2D, RdD;

    logic        BranchE, JumpE, MemWriteE, ALUSrcAE, ALUSrcBE, RegWriteE;
    logic        LdSrcE, StSrcE, ValidE, StallF, StallD, FlushD;
    logic [1:0]  ResultSrcE;
    logic [3:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic [15:0] BubbleCount;

    logic        s_BranchE, s_JumpE, s_MemWriteE, s_ALUSrcAE, s_ALUSrcBE, s_RegWriteE;
    logic        s_LdSrcE, s_StSrcE, s_ValidE, s_StallF, s_StallD, s_FlushD;
    logic [1:0]  s_ResultSrcE;
    logic [3:0]  s_ALUControlE;
    logic [31:0] s_RD1E, s_RD2E, s_PCE, s_ImmExtE, s_PCPlus4E;
    logic [4:0]  s_Rs1E, s_Rs2E, s_RdE;
    logic [3:0]  s_BubbleCount;

    typedef struct packed {
        logic        valid;
        logic        regw;
        logic [1:0]  rsrc;
        logic        memw;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
    } d_t;

    typedef struct packed {
        logic        valid;
        logic        regw;
        logic        memw;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [15:0] bc;
        logic        stall;
        logic        flush;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .HoldIn(HoldIn), .ValidD(ValidD),
        .BranchD(BranchD), .JumpD(JumpD), .ResultSrcD(ResultSrcD),
        .MemWriteD(MemWriteD), .ALUSrcAD(ALUSrcAD), .ALUSrcBD(ALUSrcBD),
        .RegWriteD(RegWriteD), .LdSrcD(LdSrcD), .StSrcD(StSrcD),
        .ALUControlD(ALUControlD), .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD),
        .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .RdD(RdD), .PCSrcE(PCSrcE),
        .BranchE(BranchE), .JumpE(JumpE), .ResultSrcE(ResultSrcE),
        .MemWriteE(MemWriteE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
        .RegWriteE(RegWriteE), .LdSrcE(LdSrcE), .StSrcE(StSrcE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE),
        .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .ValidE(ValidE), .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .BubbleCount(BubbleCount)
    );

    // Narrow-counter copy sharing the same stimulus, used to see saturation at 15.
    id_ex_stage #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .HoldIn(HoldIn), .ValidD(ValidD),
        .BranchD(BranchD), .JumpD(JumpD), .ResultSrcD(ResultSrcD),
        .MemWriteD(MemWriteD), .ALUSrcAD(ALUSrcAD), .ALUSrcBD(ALUSrcBD),
        .RegWriteD(RegWriteD), .LdSrcD(LdSrcD), .StSrcD(StSrcD),
        .ALUControlD(ALUControlD), .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD),
        .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .RdD(RdD), .PCSrcE(PCSrcE),
        .BranchE(s_BranchE), .JumpE(s_JumpE), .ResultSrcE(s_ResultSrcE),
        .MemWriteE(s_MemWriteE), .ALUSrcAE(s_ALUSrcAE), .ALUSrcBE(s_ALUSrcBE),
        .RegWriteE(s_RegWriteE), .LdSrcE(s_LdSrcE), .StSrcE(s_StSrcE),
        .ALUControlE(s_ALUControlE), .RD1E(s_RD1E), .RD2E(s_RD2E), .PCE(s_PCE),
        .ImmExtE(s_ImmExtE), .PCPlus4E(s_PCPlus4E), .Rs1E(s_Rs1E), .Rs2E(s_Rs2E),
        .RdE(s_RdE), .ValidE(s_ValidE), .StallF(s_StallF), .StallD(s_StallD),
        .FlushD(s_FlushD), .BubbleCount(s_BubbleCount)
    );

    function automatic d_t nop();
        return '0;
    endfunction

    function automatic d_t lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
        d_t d = '0;
        d.valid = 1'b1; d.regw = 1'b1; d.rsrc = 2'b01;
        d.rs1 = rs1; d.rd = rd; d.imm = imm;
        return d;
    endfunction

    function automatic d_t add(input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] imm);
        d_t d = '0;
        d.valid = 1'b1; d.regw = 1'b1;
        d.rs1 = rs1; d.rs2 = rs2; d.rd = rd; d.imm = imm;
        return d;
    endfunction

    function automatic d_t sw(input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        d_t d = '0;
        d.valid = 1'b1; d.memw = 1'b1;
        d.rs1 = rs1; d.rs2 = rs2; d.imm = imm;
        return d;
    endfunction

    function automatic exp_t ex(input logic v, input logic rw, input logic mw, input logic [4:0] rd,
                                input logic [31:0] imm, input logic [15:0] bc,
                                input logic st, input logic fl);
        exp_t e;
        e.valid = v; e.regw = rw; e.memw = mw; e.rd = rd; e.imm = imm;
        e.bc = bc; e.stall = st; e.flush = fl;
        return e;
    endfunction

    // Expectation describes what is visible at the next negedge: E state from
    // the edge just passed, stall/flush for the inputs applied now.
    task automatic step(input logic rst, input d_t d, input logic pc, input logic hold, input exp_t e);
        @(posedge clk);
        #2;
        rst_n       = rst;
        ValidD      = d.valid;
        RegWriteD   = d.regw;
        ResultSrcD  = d.rsrc;
        MemWriteD   = d.memw;
        Rs1D        = d.rs1;
        Rs2D        = d.rs2;
        RdD         = d.rd;
        ImmExtD     = d.imm;
        BranchD     = 1'b0;
        JumpD       = 1'b0;
        ALUSrcAD    = d.imm[0];
        ALUSrcBD    = d.imm[1];
        LdSrcD      = d.rsrc[0];
        StSrcD      = d.memw;
        ALUControlD = d.imm[5:2];
        RD1D        = d.imm ^ 32'h1111_0000;
        RD2D        = d.imm ^ 32'h2222_0000;
        PCD         = d.imm + 32'h100;
        PCPlus4D    = d.imm + 32'h104;
        PCSrcE      = pc;
        HoldIn      = hold;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at vector %0d: got %0h, expected %0h", name, n_vec, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [15:0] bc4;
            e   = q.pop_front();
            bc4 = (e.bc > 16'd15) ? 16'd15 : e.bc;
            n_vec++;
            chk("ValidE",      {31'd0, ValidE},      {31'd0, e.valid});
            chk("RegWriteE",   {31'd0, RegWriteE},   {31'd0, e.regw});
            chk("MemWriteE",   {31'd0, MemWriteE},   {31'd0, e.memw});
            chk("RdE",         {27'd0, RdE},         {27'd0, e.rd});
            chk("ImmExtE",     ImmExtE,              e.imm);
            chk("BubbleCount", {16'd0, BubbleCount}, {16'd0, e.bc});
            chk("BubbleCount4",{28'd0, s_BubbleCount}, {16'd0, bc4});
            chk("StallF",      {31'd0, StallF},      {31'd0, e.stall});
            chk("StallD",      {31'd0, StallD},      {31'd0, e.stall});
            chk("FlushD",      {31'd0, FlushD},      {31'd0, e.flush});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; HoldIn = 1'b0; PCSrcE = 1'b0;
        ValidD = 1'b0; BranchD = 1'b0; JumpD = 1'b0; ResultSrcD = 2'b00;
        MemWriteD = 1'b0; ALUSrcAD = 1'b0; ALUSrcBD = 1'b0; RegWriteD = 1'b0;
        LdSrcD = 1'b0; StSrcD = 1'b0; ALUControlD = 4'd0;
        RD1D = '0; RD2D = '0; PCD = '0; ImmExtD = '0; PCPlus4D = '0;
        Rs1D = '0; Rs2D = '0; RdD = '0;

        // reset state; FlushD follows PCSrcE while E is empty
        step(1'b0, nop(),                 1'b1, 1'b0, ex(0,0,0,0,0,0,0,1));
        step(1'b1, lw(5,1,4),             1'b0, 1'b0, ex(0,0,0,0,0,0,0,0));
        // load-use on rs1: stall, then bubble, then add enters
        step(1'b1, add(6,5,2,11),         1'b0, 1'b0, ex(1,1,0,5,4,0,1,0));
        step(1'b1, add(6,5,2,11),         1'b0, 1'b0, ex(0,0,0,0,0,1,0,0));
        step(1'b1, lw(0,3,8),             1'b0, 1'b0, ex(1,1,0,6,11,1,0,0));
        // load into x0 never stalls
        step(1'b1, add(7,0,0,12),         1'b0, 1'b0, ex(1,1,0,0,8,1,0,0));
        step(1'b1, lw(9,1,16),            1'b0, 1'b0, ex(1,1,0,7,12,1,0,0));
        // hold three cycles over a load-use on rs2; flush masked by hold
        step(1'b1, add(10,1,9,20),        1'b0, 1'b1, ex(1,1,0,9,16,1,1,0));
        step(1'b1, add(10,1,9,20),        1'b0, 1'b1, ex(1,1,0,9,16,1,1,0));
        step(1'b1, add(10,1,9,20),        1'b1, 1'b1, ex(1,1,0,9,16,1,1,0));
        step(1'b1, add(10,1,9,20),        1'b0, 1'b0, ex(1,1,0,9,16,1,1,0));
        step(1'b1, add(10,1,9,20),        1'b0, 1'b0, ex(0,0,0,0,0,2,0,0));
        // taken branch flushes a store
        step(1'b1, sw(2,3,24),            1'b1, 1'b0, ex(1,1,0,10,20,2,0,1));
        step(1'b1, sw(2,3,24),            1'b0, 1'b0, ex(0,0,0,0,0,3,0,0));
        step(1'b1, nop(),                 1'b0, 1'b0, ex(1,0,1,0,24,3,0,0));
        // invalid D loads without counting; then flush + load-use together
        step(1'b1, lw(5,1,4),             1'b0, 1'b0, ex(0,0,0,0,0,3,0,0));
        step(1'b1, add(6,5,2,11),         1'b1, 1'b0, ex(1,1,0,5,4,3,0,1));
        step(1'b1, nop(),                 1'b0, 1'b0, ex(0,0,0,0,0,4,0,0));
        step(1'b1, lw(5,1,4),             1'b1, 1'b0, ex(0,0,0,0,0,4,0,1));
        step(1'b1, lw(5,1,4),             1'b1, 1'b0, ex(0,0,0,0,0,5,0,1));
        step(1'b1, lw(5,1,4),             1'b1, 1'b0, ex(0,0,0,0,0,6,0,1));
        step(1'b1, lw(5,1,4),             1'b0, 1'b0, ex(0,0,0,0,0,7,0,0));
        step(1'b1, add(6,5,2,11),         1'b0, 1'b1, ex(1,1,0,5,4,7,1,0));
        // async reset between edges while stalled with RegWriteE=1, count=7
        step(1'b0, add(6,5,2,11),         1'b0, 1'b0, ex(0,0,0,0,0,0,0,0));
        step(1'b1, add(6,5,2,11),         1'b0, 1'b0, ex(0,0,0,0,0,0,0,0));
        step(1'b1, nop(),                 1'b0, 1'b0, ex(1,1,0,6,11,0,0,0));
        // 17 flush bubbles: wide counter reaches 17, narrow one pins at 15
        for (int k = 1; k <= 17; k++)
            step(1'b1, nop(),             1'b1, 1'b0, ex(0,0,0,0,0,16'(k-1),0,1));
        step(1'b1, nop(),                 1'b0, 1'b0, ex(0,0,0,0,0,17,0,0));

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
